// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

  // Frame FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Scan-code prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // True when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser for the PS/2 lines, glitch filter on the clock line
// and a one-cycle strobe on every filtered falling edge.
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic CLK,
  input  logic ARST_L,
  input  logic PS2_CLK,
  input  logic PS2_DATA,
  output logic clk_fall,
  output logic data_s
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          clk_meta;
  logic          clk_sync;
  logic          dat_meta;
  logic          dat_sync;
  logic          clk_filt;
  logic [CW-1:0] run_cnt;

  // Synchronisers reset to the idle-bus level so release never looks like an edge
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_sync <= clk_meta;
      dat_meta <= PS2_DATA;
      dat_sync <= dat_meta;
    end
  end

  // Filtered clock flips on the FILTER_LEN-th consecutive differing sample
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      clk_filt <= 1'b1;
      run_cnt  <= '0;
      clk_fall <= 1'b0;
    end else begin
      clk_fall <= 1'b0;
      if (clk_sync == clk_filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CNT_LAST) begin
        clk_filt <= clk_sync;
        run_cnt  <= '0;
        clk_fall <= clk_filt;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  assign data_s = dat_sync;

endmodule

// File: rtl/ps2_kb_ctrl.sv
// PS/2 keyboard receiver: frame decoding, E0/F0 prefix handling and a
// single-entry output register with valid/ready handshake.
import ps2_pkg::*;

module ps2_kb_ctrl #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       CLK,
  input  logic       ARST_L,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXT,
  output logic       KEY_UP,
  output logic       KEY_VALID,
  input  logic       KEY_READY,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       BUSY
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

  logic          fall;
  logic          dat;
  ps2_state_t    state_q;
  ps2_state_t    state_d;
  logic [7:0]    shreg_q;
  logic [2:0]    bitcnt_q;
  logic          par_q;
  logic          ext_q;
  logic          up_q;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          frame_ok;
  logic          frame_bad;
  logic          timeout;
  logic          new_evt;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt (
    .CLK     (CLK),
    .ARST_L  (ARST_L),
    .PS2_CLK (PS2_CLK),
    .PS2_DATA(PS2_DATA),
    .clk_fall(fall),
    .data_s  (dat)
  );

  // Frame state register
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state, frame verdict and timeout detection
  always_comb begin
    state_d   = state_q;
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    tmo_d     = tmo_q;
    if (state_q == ST_IDLE || fall) tmo_d = '0;
    else if (tmo_q != TMO_MAX)      tmo_d = tmo_q + 1'b1;
    timeout = (state_q != ST_IDLE) && (tmo_d == TMO_MAX);
    unique case (state_q)
      ST_IDLE:   if (fall && !dat) state_d = ST_DATA;
      ST_DATA:   if (fall && bitcnt_q == 3'd7) state_d = ST_PARITY;
      ST_PARITY: if (fall) state_d = ST_STOP;
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (odd_parity_ok(shreg_q, par_q) && dat) frame_ok  = 1'b1;
          else                                      frame_bad = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;
    new_evt = frame_ok && (shreg_q != PS2_EXT) && (shreg_q != PS2_BRK);
  end

  // Bit shifting, prefix flags and the timeout counter
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      shreg_q  <= '0;
      bitcnt_q <= '0;
      par_q    <= 1'b0;
      ext_q    <= 1'b0;
      up_q     <= 1'b0;
      tmo_q    <= '0;
    end else begin
      tmo_q <= tmo_d;
      if (state_q == ST_IDLE) bitcnt_q <= '0;
      if (state_q == ST_DATA && fall) begin
        shreg_q  <= {dat, shreg_q[7:1]};
        bitcnt_q <= bitcnt_q + 1'b1;
      end
      if (state_q == ST_PARITY && fall) par_q <= dat;
      if (frame_ok) begin
        if (shreg_q == PS2_EXT)      ext_q <= 1'b1;
        else if (shreg_q == PS2_BRK) up_q  <= 1'b1;
        else begin
          ext_q <= 1'b0;
          up_q  <= 1'b0;
        end
      end
      if (frame_bad || timeout) begin
        ext_q <= 1'b0;
        up_q  <= 1'b0;
      end
    end
  end

  // Output event register; a same-cycle handshake frees the slot for the new event
  always_ff @(posedge CLK or negedge ARST_L) begin
    if (!ARST_L) begin
      KEY_CODE  <= '0;
      KEY_EXT   <= 1'b0;
      KEY_UP    <= 1'b0;
      KEY_VALID <= 1'b0;
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= frame_bad || timeout;
      OVERRUN   <= 1'b0;
      if (new_evt) begin
        if (!KEY_VALID || KEY_READY) begin
          KEY_CODE  <= shreg_q;
          KEY_EXT   <= ext_q;
          KEY_UP    <= up_q;
          KEY_VALID <= 1'b1;
        end else begin
          OVERRUN <= 1'b1;
        end
      end else if (KEY_VALID && KEY_READY) begin
        KEY_VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state_q != ST_IDLE);

endmodule
